rs_issue_select: RTL and testbench
==================================

// Module: rs_issue_select
// PURPOSE
//  Age-ordered issue selector placed directly downstream of the reservation station.
//  Tracks the allocation order of every RS entry in an age matrix.
//  Each cycle it picks the oldest ready entries, up to one per FU port.
//  It drives the RS issue_grant vector and the per-port sel_idx read indices.
// PARAMETERS
//  Cfg        config_pkg::EmptyCfg        global configuration
//  RS_DEPTH   Cfg.RS_DEPTH                number of RS entries
//  RS_IDX_W   $clog2(Cfg.RS_DEPTH)        entry index width
//  NUM_PORTS  4                           FU issue ports (ALU 0..3)
// PORTS
//  clk             in   1                   clock
//  rst             in   1                   synchronous active-high reset
//  flush_i         in   1                   pipeline flush
//  entry_wen_i     in   RS_DEPTH            RS allocate strobes (same vector the RS sees)
//  ready_mask_i    in   RS_DEPTH            RS ready_mask (busy, operands ready, head-gated)
//  busy_vector_i   in   RS_DEPTH            RS busy_vector
//  fu_ready_i      in   NUM_PORTS           port p can accept an op this cycle
//  issue_grant_o   out  RS_DEPTH            one-hot-per-port grant vector to the RS
//  sel_idx_o       out  NUM_PORTS x RS_IDX_W   RS read index per port
//  sel_valid_o     out  NUM_PORTS           port p issues this cycle
//  perf_issue_cnt_o  out 32                 (PERF only) total grants
//  perf_stall_cnt_o  out 32                 (PERF only) cycles with ready entries and zero grants
// BEHAVIOUR
//  - Clock and reset: single clock clk; reset rst is synchronous and active-high.
//  - Age matrix: bit older[i][j] = 1 means entry i was allocated before entry j.
//      Bits are meaningful only while both entries are busy.
//  - Reset or flush: all older bits clear at the next edge.
//  - While rst=1: issue_grant_o, sel_valid_o and sel_idx_o are forced to 0.
//  - Allocation of entry i (entry_wen_i[i] = 1):
//      older[j][i] <= 1 for every j with busy_vector_i[j] = 1 and issue_grant_o[j] = 0.
//      older[i][*] <= 0.
//  - Multiple allocations in one cycle: the lower index is older.
//      For allocated pair a < b: older[a][b] <= 1, older[b][a] <= 0.
//  - Grant of entry i: row i and column i clear at the next edge.
//  - Selection (combinational, zero latency, same cycle as ready_mask_i):
//      candidates = ready_mask_i.
//      Oldest candidate: the entry i with no candidate j such that older[j][i] = 1.
//      Ports are served in ascending index; only ports with fu_ready_i[p] = 1 take a candidate.
//      Each port takes the oldest remaining candidate, and that candidate is then removed.
//      A port with fu_ready_i[p] = 0 is skipped; the next ready port takes that entry.
//  - Idle port (no candidate or fu_ready_i[p] = 0): sel_valid_o[p] = 0, sel_idx_o[p] = 0.
//  - issue_grant_o = OR of the one-hot vectors of all ports with sel_valid_o set.
//      At most NUM_PORTS bits are set; no entry is granted to two ports.
//  - Flush cycle: outputs are still computed. The RS ignores them because it clears busy on flush.
//  - Grant and allocate of the same entry in the same cycle is illegal.
//      The dispatch stage allocates only non-busy entries.
//      Assertion: (entry_wen_i & busy_vector_i) == 0.
//  - Assertions:
//      ready_mask_i is a subset of busy_vector_i.
//      For every busy pair i != j: older[i][j] XOR older[j][i] = 1.
// CONFIGURATION
//  - Macro RS_ISSUE_SEL_PERF_EN defined:
//      perf_issue_cnt_o += popcount(issue_grant_o) each cycle.
//      perf_stall_cnt_o += 1 when ready_mask_i != 0 and issue_grant_o == 0.
//      Both are 32-bit wrapping counters.
//      Both reset to 0 on rst only; flush does not clear them.
//  - Macro undefined: perf ports and counters are absent; selection behaviour is identical.
// STRUCTURE
//  - Shared package issue_pkg:
//      NUM_ISSUE_PORTS = 4.
//      typedef rs_idx_t (logic [RS_IDX_W-1:0]).
//      Function onehot_to_idx.
//  - Sub-module rs_age_matrix:
//      Holds the older[][] flops plus the alloc and free update logic.
//      Exposes an oldest_of(mask) combinational output.
//      rs_issue_select instantiates one and cascades oldest_of per port.
// TESTING
//  1. Age order:
//       Stimulus: alloc entry 3, then 1, then 5 in successive cycles; all ready; fu_ready = 4'b0001.
//       Required: grant order is 3, then 1, then 5, with sel_idx_o[0] = 3, 1, 5.
//  2. Same-cycle allocation:
//       Stimulus: entry_wen = 0b0110 in one cycle; both ready; fu_ready = 4'b0001.
//       Required: entry 1 is granted first, entry 2 the next cycle.
//  3. Multi-port:
//       Stimulus: 6 ready entries with ages e4 < e0 < e7 < e2 < e5 < e1; fu_ready = 4'b1111.
//       Required: sel_idx = {4, 0, 7, 2}; issue_grant = 0x95.
//  4. Backpressure:
//       Stimulus: same state as test 3; fu_ready = 4'b1010.
//       Required: port1 = 4, port3 = 0; ports 0 and 2 have sel_valid = 0.
//       Required next cycle: entry 7 is oldest.
//  5. Flush and reset:
//       Stimulus: flush with 4 busy entries, then alloc entries 6 and then 2.
//       Required: 6 is granted before 2.
//       Stimulus: rst held high with ready_mask = all ones.
//       Required: all outputs are 0.
//  6. PERF (macro defined):
//       Stimulus: 3 cycles with ready entries and fu_ready = 0, then one cycle granting 2 entries.
//       Required: perf_stall_cnt_o = 3, perf_issue_cnt_o = 2.

Source files
------------

// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared sizing, types and selection helpers for the RS issue selector
package issue_pkg;

    localparam int RS_DEPTH        = 8;
    localparam int RS_IDX_W        = $clog2(RS_DEPTH);
    localparam int NUM_ISSUE_PORTS = 4;

    typedef logic [RS_IDX_W-1:0]              rs_idx_t;
    typedef logic [RS_DEPTH-1:0]              rs_vec_t;
    // age_mat_t[a][b]: row a, column b
    typedef logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_mat_t;

    function automatic rs_idx_t onehot_to_idx(input rs_vec_t oh);
        rs_idx_t idx;
        idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (oh[i]) begin
                idx = idx | rs_idx_t'(i);
            end
        end
        return idx;
    endfunction

    // older_col[i][j] = 1 means entry j is older than entry i.
    // Returns the one-hot oldest member of mask (all zero when mask is empty).
    // The lowest-index winner is taken so the result stays one-hot even if
    // the matrix were ever inconsistent.
    function automatic rs_vec_t oldest_of(input rs_vec_t mask, input age_mat_t older_col);
        rs_vec_t hit;
        logic    found;
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!found && mask[i] && ((mask & older_col[i]) == '0)) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/rs_issue_select_age_matrix.sv
// rtl/rs_issue_select_age_matrix.sv - age matrix flops with alloc/free update and oldest-of query
//
// Module rs_age_matrix
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   flush_i      in   pipeline flush, clears every age bit
//   alloc_i      in   RS allocate strobes
//   grant_i      in   entries issued this cycle (freed next edge)
//   busy_i       in   RS busy vector
//   mask_i       in   query mask for oldest_o
//   oldest_o     out  one-hot oldest entry of mask_i
//   older_col_o  out  older_col_o[i][j] = entry j is older than entry i
module rs_age_matrix
    import issue_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush_i,
    input  rs_vec_t  alloc_i,
    input  rs_vec_t  grant_i,
    input  rs_vec_t  busy_i,
    input  rs_vec_t  mask_i,
    output rs_vec_t  oldest_o,
    output age_mat_t older_col_o
);

    // r_older[i][j] = 1: entry i was allocated before entry j
    age_mat_t r_older;
    age_mat_t w_older_nxt;
    logic     w_age_ok;

    always_comb begin
        w_older_nxt = r_older;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (i == j) begin
                    w_older_nxt[i][j] = 1'b0;
                end else if (grant_i[i] || grant_i[j]) begin
                    // a freed entry drops out of both its row and its column
                    w_older_nxt[i][j] = 1'b0;
                end else if (alloc_i[i]) begin
                    // new entry is younger than everything except a same-cycle
                    // allocation at a higher index
                    w_older_nxt[i][j] = alloc_i[j] && (i < j);
                end else if (alloc_i[j]) begin
                    // every surviving busy entry is older than the newcomer
                    w_older_nxt[i][j] = busy_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_older <= '0;
        end else begin
            r_older <= w_older_nxt;
        end
    end

    always_comb begin
        older_col_o = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                older_col_o[i][j] = r_older[j][i];
            end
        end
    end

    assign oldest_o = oldest_of(mask_i, older_col_o);

    // exactly one direction of age must hold between any two busy entries
    always_comb begin
        w_age_ok = 1'b1;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (i != j && busy_i[i] && busy_i[j] && !(r_older[i][j] ^ r_older[j][i])) begin
                    w_age_ok = 1'b0;
                end
            end
        end
    end

    a_age_pairwise: assert property (@(posedge clk) disable iff (rst) w_age_ok);

endmodule

// File: rtl/rs_issue_select.sv
// rtl/rs_issue_select.sv - age-ordered issue selector, oldest ready entry per FU port
//
// Optional feature: define RS_ISSUE_SEL_PERF_EN to add the perf counter ports.
//
// Ports
//   clk               in   clock
//   rst               in   synchronous active-high reset
//   flush_i           in   pipeline flush
//   entry_wen_i       in   RS allocate strobes
//   ready_mask_i      in   RS ready mask (subset of busy)
//   busy_vector_i     in   RS busy vector
//   fu_ready_i        in   per-port accept
//   issue_grant_o     out  OR of all per-port one-hot grants
//   sel_idx_o         out  RS read index per port (0 when idle)
//   sel_valid_o       out  port issues this cycle
//   perf_issue_cnt_o  out  total grants (RS_ISSUE_SEL_PERF_EN)
//   perf_stall_cnt_o  out  cycles with ready entries and no grant (RS_ISSUE_SEL_PERF_EN)
module rs_issue_select
    import issue_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush_i,
    input  logic [RS_DEPTH-1:0]                     entry_wen_i,
    input  logic [RS_DEPTH-1:0]                     ready_mask_i,
    input  logic [RS_DEPTH-1:0]                     busy_vector_i,
    input  logic [NUM_ISSUE_PORTS-1:0]              fu_ready_i,
    output logic [RS_DEPTH-1:0]                     issue_grant_o,
    output logic [NUM_ISSUE_PORTS-1:0][RS_IDX_W-1:0] sel_idx_o,
    output logic [NUM_ISSUE_PORTS-1:0]              sel_valid_o
`ifdef RS_ISSUE_SEL_PERF_EN
    ,
    output logic [31:0]                             perf_issue_cnt_o,
    output logic [31:0]                             perf_stall_cnt_o
`endif
);

    rs_vec_t  w_oldest;
    age_mat_t w_older_col;

    rs_age_matrix u_age (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .alloc_i     (entry_wen_i),
        .grant_i     (issue_grant_o),
        .busy_i      (busy_vector_i),
        .mask_i      (ready_mask_i),
        .oldest_o    (w_oldest),
        .older_col_o (w_older_col)
    );

    // Port cascade: each ready port takes the oldest remaining candidate.
    // The first taker sees the full ready mask, so it reuses the matrix's own
    // oldest_o; later ports re-query with the winners removed.
    always_comb begin : p_select
        rs_vec_t w_rem;
        rs_vec_t w_pick;
        logic    w_first;
        issue_grant_o = '0;
        sel_valid_o   = '0;
        sel_idx_o     = '0;
        w_rem         = ready_mask_i;
        w_pick        = '0;
        w_first       = 1'b1;
        if (!rst) begin
            for (int p = 0; p < NUM_ISSUE_PORTS; p++) begin
                if (fu_ready_i[p] && (w_rem != '0)) begin
                    w_pick  = w_first ? w_oldest : oldest_of(w_rem, w_older_col);
                    w_first = 1'b0;
                    if (w_pick != '0) begin
                        sel_valid_o[p] = 1'b1;
                        sel_idx_o[p]   = onehot_to_idx(w_pick);
                        issue_grant_o  = issue_grant_o | w_pick;
                        w_rem          = w_rem & ~w_pick;
                    end
                end
            end
        end
    end

`ifdef RS_ISSUE_SEL_PERF_EN
    logic [31:0] r_perf_issue_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_issue_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            r_perf_issue_cnt <= r_perf_issue_cnt + 32'($countones(issue_grant_o));
            if ((ready_mask_i != '0) && (issue_grant_o == '0)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_issue_cnt_o = r_perf_issue_cnt;
    assign perf_stall_cnt_o = r_perf_stall_cnt;
`endif

    // dispatch only allocates free entries, so allocate and grant never collide
    a_alloc_not_busy: assert property (@(posedge clk) disable iff (rst)
        (entry_wen_i & busy_vector_i) == '0);
    a_ready_in_busy: assert property (@(posedge clk) disable iff (rst)
        (ready_mask_i & ~busy_vector_i) == '0);

endmodule

// File: tb/tb_rs_issue_select.sv
// tb/tb_rs_issue_select.sv - directed self-checking bench for rs_issue_select
module tb_rs_issue_select;
    import issue_pkg::*;

    logic                                     clk = 1'b0;
    logic                                     rst;
    logic                                     flush;
    rs_vec_t                                  wen;
    rs_vec_t                                  ready;
    rs_vec_t                                  busy;
    logic [NUM_ISSUE_PORTS-1:0]               fu;
    rs_vec_t                                  grant;
    logic [NUM_ISSUE_PORTS-1:0][RS_IDX_W-1:0] sel_idx;
    logic [NUM_ISSUE_PORTS-1:0]               sel_valid;
`ifdef RS_ISSUE_SEL_PERF_EN
    logic [31:0]                              perf_issue;
    logic [31:0]                              perf_stall;
`endif

    int      checks   = 0;
    int      failures = 0;
    rs_vec_t m_busy   = '0;

    always #5 clk = ~clk;

    rs_issue_select dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .entry_wen_i   (wen),
        .ready_mask_i  (ready),
        .busy_vector_i (busy),
        .fu_ready_i    (fu),
        .issue_grant_o (grant),
        .sel_idx_o     (sel_idx),
        .sel_valid_o   (sel_valid)
`ifdef RS_ISSUE_SEL_PERF_EN
        ,
        .perf_issue_cnt_o (perf_issue),
        .perf_stall_cnt_o (perf_stall)
`endif
    );

    task automatic drive(input rs_vec_t w, input rs_vec_t rdy, input logic [3:0] f);
        wen   = w;
        ready = rdy;
        busy  = m_busy;
        fu    = f;
        #1;
    endtask

    // commit one edge; the RS model frees granted entries and marks allocations busy
    task automatic advance(input rs_vec_t exp_grant);
        @(posedge clk);
        #1;
        m_busy = (m_busy & ~exp_grant) | wen;
        wen    = '0;
        busy   = m_busy;
        ready  = '0;
    endtask

    task automatic alloc(input rs_vec_t w);
        drive(w, '0, 4'b0000);
        advance('0);
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        flush  = 1'b0;
        m_busy = '1;
        drive('0, '1, 4'b1111);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (grant !== '0) begin
            failures++;
            $display("FAIL reset_grant got=%h exp=00", grant);
        end
        checks++;
        if (sel_valid !== 4'b0000 || sel_idx !== '0) begin
            failures++;
            $display("FAIL reset_sel got_valid=%b got_idx=%h exp=0", sel_valid, sel_idx);
        end
        rst    = 1'b0;
        m_busy = '0;
        drive('0, '0, 4'b1111);
        checks++;
        if (grant !== '0 || sel_valid !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle got_grant=%h got_valid=%b exp=0", grant, sel_valid);
        end
        advance('0);
    endtask

    task automatic test_age_order;
        int exp_e[3] = '{3, 1, 5};
        alloc(8'h08);
        alloc(8'h02);
        alloc(8'h20);
        for (int k = 0; k < 3; k++) begin
            drive('0, m_busy, 4'b0001);
            checks++;
            if (grant !== (rs_vec_t'(1) << exp_e[k]) || sel_valid !== 4'b0001) begin
                failures++;
                $display("FAIL age_order_grant[%0d] got=%h valid=%b exp=%h", k, grant, sel_valid,
                         rs_vec_t'(1) << exp_e[k]);
            end
            checks++;
            if (sel_idx[0] !== rs_idx_t'(exp_e[k])) begin
                failures++;
                $display("FAIL age_order_idx[%0d] got=%0d exp=%0d", k, sel_idx[0], exp_e[k]);
            end
            advance(rs_vec_t'(1) << exp_e[k]);
        end
    endtask

    task automatic test_same_cycle;
        int exp_e[2] = '{1, 2};
        alloc(8'h06);
        for (int k = 0; k < 2; k++) begin
            drive('0, m_busy, 4'b0001);
            checks++;
            if (grant !== (rs_vec_t'(1) << exp_e[k]) || sel_idx[0] !== rs_idx_t'(exp_e[k])) begin
                failures++;
                $display("FAIL same_cycle[%0d] got_grant=%h got_idx=%0d exp_idx=%0d", k, grant,
                         sel_idx[0], exp_e[k]);
            end
            advance(rs_vec_t'(1) << exp_e[k]);
        end
    endtask

    task automatic test_multi_port;
        int order[6] = '{4, 0, 7, 2, 5, 1};
        logic [NUM_ISSUE_PORTS-1:0][RS_IDX_W-1:0] exp_idx;
        for (int k = 0; k < 6; k++) begin
            alloc(rs_vec_t'(1) << order[k]);
        end
        drive('0, m_busy, 4'b1111);
        exp_idx[0] = 3'd4;
        exp_idx[1] = 3'd0;
        exp_idx[2] = 3'd7;
        exp_idx[3] = 3'd2;
        checks++;
        if (grant !== 8'h95) begin
            failures++;
            $display("FAIL multi_port_grant got=%h exp=95", grant);
        end
        checks++;
        if (sel_idx !== exp_idx || sel_valid !== 4'b1111) begin
            failures++;
            $display("FAIL multi_port_idx got=%h valid=%b exp=%h", sel_idx, sel_valid, exp_idx);
        end
    endtask

    // continues from the state left by test_multi_port
    task automatic test_backpressure;
        logic [NUM_ISSUE_PORTS-1:0][RS_IDX_W-1:0] exp_idx;
        drive('0, m_busy, 4'b1010);
        exp_idx    = '0;
        exp_idx[1] = 3'd4;
        exp_idx[3] = 3'd0;
        checks++;
        if (sel_valid !== 4'b1010 || sel_idx !== exp_idx) begin
            failures++;
            $display("FAIL backpressure_sel got_valid=%b got_idx=%h exp_idx=%h", sel_valid, sel_idx, exp_idx);
        end
        checks++;
        if (grant !== 8'h11) begin
            failures++;
            $display("FAIL backpressure_grant got=%h exp=11", grant);
        end
        advance(8'h11);
        drive('0, m_busy, 4'b0000);
        checks++;
        if (grant !== '0 || sel_valid !== 4'b0000 || sel_idx !== '0) begin
            failures++;
            $display("FAIL no_fu_ready got_grant=%h valid=%b idx=%h exp=0", grant, sel_valid, sel_idx);
        end
        drive('0, m_busy, 4'b0001);
        checks++;
        if (sel_idx[0] !== 3'd7 || grant !== 8'h80) begin
            failures++;
            $display("FAIL backpressure_next got_idx=%0d grant=%h exp_idx=7", sel_idx[0], grant);
        end
        drive('0, m_busy, 4'b1111);
        exp_idx[0] = 3'd7;
        exp_idx[1] = 3'd2;
        exp_idx[2] = 3'd5;
        exp_idx[3] = 3'd1;
        checks++;
        if (grant !== 8'hA6 || sel_idx !== exp_idx) begin
            failures++;
            $display("FAIL drain got_grant=%h got_idx=%h exp_grant=a6 exp_idx=%h", grant, sel_idx, exp_idx);
        end
        advance(8'hA6);
    endtask

    task automatic test_flush_reset;
        alloc(8'h0F);
        flush = 1'b1;
        drive('0, m_busy, 4'b0001);
        checks++;
        if (grant !== 8'h01 || sel_idx[0] !== 3'd0) begin
            failures++;
            $display("FAIL flush_cycle got_grant=%h got_idx=%0d exp_grant=01", grant, sel_idx[0]);
        end
        advance(8'h01);
        flush  = 1'b0;
        m_busy = '0;
        busy   = '0;
        alloc(8'h40);
        alloc(8'h04);
        drive('0, m_busy, 4'b0001);
        checks++;
        if (grant !== 8'h40 || sel_idx[0] !== 3'd6) begin
            failures++;
            $display("FAIL flush_order_first got_grant=%h got_idx=%0d exp_idx=6", grant, sel_idx[0]);
        end
        advance(8'h40);
        drive('0, m_busy, 4'b0001);
        checks++;
        if (grant !== 8'h04 || sel_idx[0] !== 3'd2) begin
            failures++;
            $display("FAIL flush_order_second got_grant=%h got_idx=%0d exp_idx=2", grant, sel_idx[0]);
        end
        advance(8'h04);
        rst    = 1'b1;
        m_busy = '1;
        drive('0, '1, 4'b1111);
        @(posedge clk);
        #1;
        checks++;
        if (grant !== '0 || sel_valid !== 4'b0000 || sel_idx !== '0) begin
            failures++;
            $display("FAIL rst_held got_grant=%h valid=%b idx=%h exp=0", grant, sel_valid, sel_idx);
        end
        rst    = 1'b0;
        m_busy = '0;
        drive('0, '0, 4'b0000);
        advance('0);
    endtask

`ifdef RS_ISSUE_SEL_PERF_EN
    task automatic test_perf;
        checks++;
        if (perf_issue !== 32'd0 || perf_stall !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset got_issue=%0d got_stall=%0d exp=0", perf_issue, perf_stall);
        end
        alloc(8'h03);
        for (int k = 0; k < 3; k++) begin
            drive('0, m_busy, 4'b0000);
            advance('0);
        end
        drive('0, m_busy, 4'b0011);
        advance(8'h03);
        checks++;
        if (perf_stall !== 32'd3) begin
            failures++;
            $display("FAIL perf_stall got=%0d exp=3", perf_stall);
        end
        checks++;
        if (perf_issue !== 32'd2) begin
            failures++;
            $display("FAIL perf_issue got=%0d exp=2", perf_issue);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        wen   = '0;
        ready = '0;
        busy  = '0;
        fu    = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_age_order();
        test_same_cycle();
        test_multi_port();
        test_backpressure();
        test_flush_reset();
`ifdef RS_ISSUE_SEL_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
